core_control_unit: RTL and testbench



---
 rtl/core_control_unit_pkg.sv | 57 +++++
 rtl/core_control_unit_if.sv | 41 ++++
 rtl/core_reg_decode.sv | 25 ++
 rtl/core_control_unit.sv | 156 +++++++++++++++
 tb/tb_core_control_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_control_unit_pkg.sv
// Shared encodings for the core sequencer and the data-bus mux: bus select codes,
// opcodes, ALU operations, register load indices and sequencer state encoding.
package core_control_unit_pkg;

    localparam int DEF_INS_WIDTH = 8;
    localparam int BUS_SEL_W     = 4;
    localparam int ALU_OP_W      = 2;
    localparam int NUM_GP_REGS   = 6;
    localparam int STATE_W       = 3;

    localparam logic [BUS_SEL_W-1:0] DATAMEM_SEL = 4'd0;
    localparam logic [BUS_SEL_W-1:0] R_SEL       = 4'd1;
    localparam logic [BUS_SEL_W-1:0] IR_SEL      = 4'd2;
    localparam logic [BUS_SEL_W-1:0] RL_SEL      = 4'd3;
    localparam logic [BUS_SEL_W-1:0] RC_SEL      = 4'd4;
    localparam logic [BUS_SEL_W-1:0] RP_SEL      = 4'd5;
    localparam logic [BUS_SEL_W-1:0] RQ_SEL      = 4'd6;
    localparam logic [BUS_SEL_W-1:0] R1_SEL      = 4'd7;
    localparam logic [BUS_SEL_W-1:0] ACC_SEL     = 4'd8;
    localparam logic [BUS_SEL_W-1:0] IDLE_SEL    = 4'd9;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LDAC = 4'd2;
    localparam logic [3:0] OP_STAC = 4'd3;
    localparam logic [3:0] OP_MVR  = 4'd4;
    localparam logic [3:0] OP_MVA  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'd2;

    // Bit positions within the general-purpose register load vector.
    localparam int LD_R  = 0;
    localparam int LD_RL = 1;
    localparam int LD_RC = 2;
    localparam int LD_RP = 3;
    localparam int LD_RQ = 4;
    localparam int LD_R1 = 5;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC1  = 3'd3;
    localparam logic [STATE_W-1:0] ST_EXEC2  = 3'd4;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd5;

    typedef struct packed {
        logic                   vld;
        logic [BUS_SEL_W-1:0]   sel;
        logic [NUM_GP_REGS-1:0] ld;
    } reg_dec_t;

endpackage

// File: rtl/core_control_unit_if.sv
// Control bundle between one core sequencer (master) and the datapath/memory side (slave).
interface core_control_unit_if
    import core_control_unit_pkg::*;
#(
    parameter int INS_WIDTH = DEF_INS_WIDTH
);
    logic                 start;
    logic [INS_WIDTH-1:0] ir;
    logic                 mem_ack;

    logic [BUS_SEL_W-1:0] bus_sel;
    logic                 ld_ir;
    logic                 ld_ar;
    logic                 ld_r;
    logic                 ld_rl;
    logic                 ld_rc;
    logic                 ld_rp;
    logic                 ld_rq;
    logic                 ld_r1;
    logic                 ld_acc;
    logic                 addr_pc;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 pc_inc;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 illegal;
    logic                 done;

    modport master (
        input  start, ir, mem_ack,
        output bus_sel, ld_ir, ld_ar, ld_r, ld_rl, ld_rc, ld_rp, ld_rq, ld_r1, ld_acc,
        output addr_pc, mem_rd, mem_wr, pc_inc, alu_op, illegal, done
    );

    modport slave (
        output start, ir, mem_ack,
        input  bus_sel, ld_ir, ld_ar, ld_r, ld_rl, ld_rc, ld_rp, ld_rq, ld_r1, ld_acc,
        input  addr_pc, mem_rd, mem_wr, pc_inc, alu_op, illegal, done
    );

endinterface

// File: rtl/core_reg_decode.sv
// Maps a 3-bit register index to its bus select code and one-hot load enable.
// Indices 6 and 7 have no register behind them and come back with vld=0.
module core_reg_decode
    import core_control_unit_pkg::*;
(
    input  logic [2:0] reg_idx,
    output reg_dec_t   dec
);

    always_comb begin
        dec.vld = 1'b1;
        dec.sel = IDLE_SEL;
        dec.ld  = '0;
        case (reg_idx)
            3'd0: begin dec.sel = R_SEL;  dec.ld[LD_R]  = 1'b1; end
            3'd1: begin dec.sel = RL_SEL; dec.ld[LD_RL] = 1'b1; end
            3'd2: begin dec.sel = RC_SEL; dec.ld[LD_RC] = 1'b1; end
            3'd3: begin dec.sel = RP_SEL; dec.ld[LD_RP] = 1'b1; end
            3'd4: begin dec.sel = RQ_SEL; dec.ld[LD_RQ] = 1'b1; end
            3'd5: begin dec.sel = R1_SEL; dec.ld[LD_R1] = 1'b1; end
            default: dec.vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_control_unit.sv
// Per-core fetch/decode/execute sequencer driving the shared bus mux, register loads and memory strobes.
// Outputs are decoded from the state register (plus mem_ack/ir), so reset clears them without a clock.
module core_control_unit
    import core_control_unit_pkg::*;
#(
    parameter int INS_WIDTH = DEF_INS_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    core_control_unit_if.master ccu
);

    logic [STATE_W-1:0]     state_q;
    logic [STATE_W-1:0]     state_d;
    logic [3:0]             opcode;
    logic [2:0]             reg_idx;
    logic                   is_reg_op;
    logic                   unused_ir_bits;
    reg_dec_t               rdec;

    logic [BUS_SEL_W-1:0]   bus_sel;
    logic                   ld_ir;
    logic                   ld_ar;
    logic                   ld_acc;
    logic [NUM_GP_REGS-1:0] ld_gp;
    logic                   addr_pc;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   pc_inc;
    logic [ALU_OP_W-1:0]    alu_op;
    logic                   illegal;
    logic                   done;

    assign opcode         = ccu.ir[INS_WIDTH-1 -: 4];
    assign reg_idx        = ccu.ir[2:0];
    assign unused_ir_bits = ^ccu.ir[INS_WIDTH-5:3];
    assign is_reg_op      = (opcode >= OP_MVR) && (opcode <= OP_SUB);

    core_reg_decode u_reg_decode (
        .reg_idx (reg_idx),
        .dec     (rdec)
    );

    always_comb begin
        state_d = state_q;
        bus_sel = IDLE_SEL;
        ld_ir   = 1'b0;
        ld_ar   = 1'b0;
        ld_acc  = 1'b0;
        ld_gp   = '0;
        addr_pc = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        pc_inc  = 1'b0;
        alu_op  = ALU_PASS;
        illegal = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ccu.start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                addr_pc = 1'b1;
                mem_rd  = 1'b1;
                if (ccu.mem_ack) begin
                    bus_sel = DATAMEM_SEL;
                    ld_ir   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // 8..14 and register ops naming index 6/7 fall through as a flagged NOP.
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if ((opcode > OP_SUB) || (is_reg_op && !rdec.vld)) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end else if (opcode == OP_NOP) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_LDI: begin
                        bus_sel     = IR_SEL;
                        ld_gp[LD_R] = 1'b1;
                    end
                    OP_LDAC, OP_STAC: begin
                        bus_sel = R_SEL;
                        ld_ar   = 1'b1;
                        state_d = ST_EXEC2;
                    end
                    OP_MVR: begin
                        bus_sel = ACC_SEL;
                        ld_gp   = rdec.ld;
                    end
                    OP_MVA, OP_ADD, OP_SUB: begin
                        bus_sel = rdec.sel;
                        ld_acc  = 1'b1;
                        alu_op  = (opcode == OP_ADD) ? ALU_ADD :
                                  (opcode == OP_SUB) ? ALU_SUB : ALU_PASS;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (opcode == OP_STAC) begin
                    bus_sel = ACC_SEL;
                    mem_wr  = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    if (ccu.mem_ack) begin
                        bus_sel = DATAMEM_SEL;
                        ld_acc  = 1'b1;
                        alu_op  = ALU_PASS;
                    end
                end
                if (ccu.mem_ack) state_d = ST_FETCH;
            end
            ST_HALT: begin
                done = 1'b1;
                if (!ccu.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign ccu.bus_sel = bus_sel;
    assign ccu.ld_ir   = ld_ir;
    assign ccu.ld_ar   = ld_ar;
    assign ccu.ld_r    = ld_gp[LD_R];
    assign ccu.ld_rl   = ld_gp[LD_RL];
    assign ccu.ld_rc   = ld_gp[LD_RC];
    assign ccu.ld_rp   = ld_gp[LD_RP];
    assign ccu.ld_rq   = ld_gp[LD_RQ];
    assign ccu.ld_r1   = ld_gp[LD_R1];
    assign ccu.ld_acc  = ld_acc;
    assign ccu.addr_pc = addr_pc;
    assign ccu.mem_rd  = mem_rd;
    assign ccu.mem_wr  = mem_wr;
    assign ccu.pc_inc  = pc_inc;
    assign ccu.alu_op  = alu_op;
    assign ccu.illegal = illegal;
    assign ccu.done    = done;

endmodule

// File: tb/tb_core_control_unit.sv
// Bench for core_control_unit: a per-instruction model expands each instruction into the
// cycle-by-cycle output pattern it must produce, then replays it against the DUT.
module tb_core_control_unit;

    typedef struct packed {
        logic [3:0] bus_sel;
        logic       ld_ir, ld_ar, ld_r, ld_rl, ld_rc, ld_rp, ld_rq, ld_r1, ld_acc;
        logic       addr_pc, mem_rd, mem_wr, pc_inc;
        logic [1:0] alu_op;
        logic       illegal, done;
    } obs_t;

    typedef struct {
        logic       start;
        logic       ack;
        logic [7:0] ir;
        obs_t       exp;
        int         ph;
    } step_t;

    logic clk = 1'b0;
    logic rst;

    core_control_unit_if #(.INS_WIDTH(8)) ccu_if();

    core_control_unit #(.INS_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .ccu (ccu_if.master)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    step_t plan[$];
    string ph_name[9] = '{"rst", "idle", "fetch_wait", "fetch_ack", "decode",
                          "exec1", "exec2_wait", "exec2_ack", "halt"};
    int    reg_code[6] = '{1, 3, 4, 5, 6, 7};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t idle_o();
        obs_t o;
        o = '0;
        o.bus_sel = 4'd9;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.bus_sel = ccu_if.bus_sel;
        o.ld_ir   = ccu_if.ld_ir;
        o.ld_ar   = ccu_if.ld_ar;
        o.ld_r    = ccu_if.ld_r;
        o.ld_rl   = ccu_if.ld_rl;
        o.ld_rc   = ccu_if.ld_rc;
        o.ld_rp   = ccu_if.ld_rp;
        o.ld_rq   = ccu_if.ld_rq;
        o.ld_r1   = ccu_if.ld_r1;
        o.ld_acc  = ccu_if.ld_acc;
        o.addr_pc = ccu_if.addr_pc;
        o.mem_rd  = ccu_if.mem_rd;
        o.mem_wr  = ccu_if.mem_wr;
        o.pc_inc  = ccu_if.pc_inc;
        o.alu_op  = ccu_if.alu_op;
        o.illegal = ccu_if.illegal;
        o.done    = ccu_if.done;
        return o;
    endfunction

    function automatic obs_t with_ld(input obs_t o_in, input int k);
        obs_t o;
        o = o_in;
        case (k)
            0: o.ld_r  = 1'b1;
            1: o.ld_rl = 1'b1;
            2: o.ld_rc = 1'b1;
            3: o.ld_rp = 1'b1;
            4: o.ld_rq = 1'b1;
            5: o.ld_r1 = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input logic s, input logic a, input logic [7:0] irv, input obs_t o, input int ph);
        step_t e;
        e.start = s;
        e.ack   = a;
        e.ir    = irv;
        e.exp   = o;
        e.ph    = ph;
        plan.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expands one instruction, starting in FETCH, into its expected cycle sequence.
    task automatic add_instr(input logic [7:0] irv, input int fw, input int ew);
        obs_t o;
        int   op;
        int   k;
        int   n;
        op = int'(irv[7:4]);
        k  = int'(irv[2:0]);

        o = idle_o(); o.addr_pc = 1'b1; o.mem_rd = 1'b1;
        for (int i = 0; i < fw; i++) push(1'b1, 1'b0, irv, o, 2);
        o.bus_sel = 4'd0; o.ld_ir = 1'b1; o.pc_inc = 1'b1;
        push(1'b1, 1'b1, irv, o, 3);

        o = idle_o();
        o.illegal = ((op >= 8) && (op <= 14)) || ((op >= 4) && (op <= 7) && (k >= 6));
        push(1'b1, rbit(), irv, o, 4);
        if (o.illegal) return;

        case (op)
            1: begin
                o = idle_o(); o.bus_sel = 4'd2; o.ld_r = 1'b1;
                push(1'b1, rbit(), irv, o, 5);
            end
            2, 3: begin
                o = idle_o(); o.bus_sel = 4'd1; o.ld_ar = 1'b1;
                push(1'b1, rbit(), irv, o, 5);
                o = idle_o();
                if (op == 2) o.mem_rd = 1'b1;
                else begin o.mem_wr = 1'b1; o.bus_sel = 4'd8; end
                for (int i = 0; i < ew; i++) push(1'b1, 1'b0, irv, o, 6);
                if (op == 2) begin o.bus_sel = 4'd0; o.ld_acc = 1'b1; end
                push(1'b1, 1'b1, irv, o, 7);
            end
            4: begin
                o = with_ld(idle_o(), k); o.bus_sel = 4'd8;
                push(1'b1, rbit(), irv, o, 5);
            end
            5, 6, 7: begin
                o = idle_o(); o.bus_sel = 4'(reg_code[k]); o.ld_acc = 1'b1; o.alu_op = 2'(op - 5);
                push(1'b1, rbit(), irv, o, 5);
            end
            15: begin
                o = idle_o(); o.done = 1'b1;
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) push(1'b1, rbit(), irv, o, 8);
                push(1'b0, rbit(), irv, o, 8);
                o = idle_o();
                n = $urandom_range(0, 2);
                for (int i = 0; i < n; i++) push(1'b0, rbit(), irv, o, 1);
                push(1'b1, rbit(), irv, o, 1);
            end
            default: ;
        endcase
    endtask

    task automatic run_plan();
        step_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(negedge clk);
            ccu_if.start   = e.start;
            ccu_if.mem_ack = e.ack;
            ccu_if.ir      = e.ir;
            #1;
            chk_eq($sformatf("%s ir=%02h", ph_name[e.ph], e.ir), 32'(observe()), 32'(e.exp));
        end
    endtask

    initial begin
        obs_t got;
        rst            = 1'b1;
        ccu_if.start   = 1'b0;
        ccu_if.mem_ack = 1'b0;
        ccu_if.ir      = 8'h00;
        #12;
        chk_eq("reset_outputs", 32'(observe()), 32'(idle_o()));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_eq("idle_after_reset", 32'(observe()), 32'(idle_o()));

        push(1'b1, rbit(), 8'h00, idle_o(), 1);
        add_instr(8'h15, 0, 0);
        add_instr(8'h20, 1, 3);
        add_instr(8'h30, 0, 2);
        add_instr(8'h63, 2, 0);
        add_instr(8'h75, 0, 0);
        add_instr(8'h9A, 0, 0);
        add_instr(8'h46, 1, 0);
        add_instr(8'h4F, 0, 0);
        add_instr(8'h00, 0, 0);
        add_instr(8'hF0, 0, 0);
        add_instr(8'h42, 0, 0);
        add_instr(8'h51, 0, 0);
        run_plan();

        for (int t = 0; t < 300; t++) begin
            add_instr(8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3));
            run_plan();
        end

        // Asynchronous reset while LDAC is waiting on memory in EXEC2.
        add_instr(8'h20, 0, 1);
        void'(plan.pop_back());
        run_plan();
        #1 rst = 1'b1;
        #1;
        got = observe();
        chk_eq("rst_async_mem_rd", 32'(got.mem_rd), 32'(1'b0));
        chk_eq("rst_async_outputs", 32'(got), 32'(idle_o()));
        @(negedge clk);
        ccu_if.start = 1'b0;
        rst = 1'b0;
        #1;
        chk_eq("idle_after_midop_rst", 32'(observe()), 32'(idle_o()));

        push(1'b0, 1'b1, 8'h20, idle_o(), 1);
        push(1'b1, 1'b0, 8'h20, idle_o(), 1);
        add_instr(8'h63, 1, 0);
        run_plan();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
